xotr_block_out_sequencer: RTL

- Sequences the execution-phase timer (XPT) for the ED-prefixed block output group OUTI/OTIR/OUTD/OTDR (opcode 101xx011).
- Drives XPT/notXPT into the XOTR op decoder, which turns each phase into datapath strobes.
- Owns the T10 I/O wait handshake, the repeat decision for OTIR/OTDR (B≠0 re-executes), the 5-cycle repeat tail, and the PC rewind request.
- Sits between the instruction fetch/dispatch unit and the op decoder.

---
 rtl/xotr_block_out_sequencer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/xotr_block_out_sequencer.sv
// Purpose : execution-phase timer (XPT) sequencer for ED-prefixed OUTI/OTIR/OUTD/OTDR (101xx011).
// Latency : start accepted on the edge it is sampled; XPT=4 the next cycle; done 8 (+TAIL_LEN if repeating,
//           +1 per wait cycle) cycles later. Backpressure: io_wait holds XPT at 10, bounded by MAX_WAIT.
// Ports   : CLK/notReset (sync, active-low); start+Source dispatch; io_wait (sampled at XPT=10);
//           b_zero (sampled at XPT=8); XPT/notXPT phase to the op decoder; busy; dec/rep latched
//           opcode bits; pc_rewind, done, bad_op, io_timeout single-cycle pulses.
module xotr_block_out_sequencer #(
   parameter int MAX_WAIT = 255,
   parameter int TAIL_LEN = 5
) (
   input  logic       CLK,
   input  logic       notReset,
   input  logic       start,
   input  logic [7:0] Source,
   input  logic       io_wait,
   input  logic       b_zero,
   output logic [4:0] XPT,
   output logic [4:0] notXPT,
   output logic       busy,
   output logic       dec,
   output logic       rep,
   output logic       pc_rewind,
   output logic       done,
   output logic       bad_op,
   output logic       io_timeout
);

   localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);
   localparam logic [4:0] XPT_FIRST  = 5'd4;
   localparam logic [4:0] XPT_SAMPLE = 5'd8;
   localparam logic [4:0] XPT_PRE    = 5'd9;
   localparam logic [4:0] XPT_WAIT   = 5'd10;
   localparam logic [4:0] XPT_END    = 5'd11;
   localparam logic [4:0] XPT_TAIL   = 5'd12;
   localparam logic [4:0] XPT_LAST   = 5'(11 + TAIL_LEN);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_XFER = 2'd1,
      S_WAIT = 2'd2,
      S_TAIL = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [4:0] xpt_q, xpt_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       b_zero_q, b_zero_d;
   logic       dec_q, dec_d;
   logic       rep_q, rep_d;
   logic       done_q, done_d;
   logic       bad_op_q, bad_op_d;
   logic       timeout_q, timeout_d;
   logic       op_ok;

   assign op_ok = (Source[7:5] == 3'b101) && (Source[2:0] == 3'b011);

   // State register
   always_ff @(posedge CLK) begin
      if (!notReset) begin
         state_q    <= S_IDLE;
         xpt_q      <= 5'd0;
         wait_cnt_q <= 8'd0;
         b_zero_q   <= 1'b0;
         dec_q      <= 1'b0;
         rep_q      <= 1'b0;
         done_q     <= 1'b0;
         bad_op_q   <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         xpt_q      <= xpt_d;
         wait_cnt_q <= wait_cnt_d;
         b_zero_q   <= b_zero_d;
         dec_q      <= dec_d;
         rep_q      <= rep_d;
         done_q     <= done_d;
         bad_op_q   <= bad_op_d;
         timeout_q  <= timeout_d;
      end
   end

   // Next-state logic. done/bad_op/io_timeout are registered pulses so they
   // appear in the cycle after the decision, aligned with the new XPT value.
   always_comb begin
      state_d    = state_q;
      xpt_d      = xpt_q;
      wait_cnt_d = wait_cnt_q;
      b_zero_d   = b_zero_q;
      dec_d      = dec_q;
      rep_d      = rep_q;
      done_d     = 1'b0;
      bad_op_d   = 1'b0;
      timeout_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (op_ok) begin
                  state_d = S_XFER;
                  xpt_d   = XPT_FIRST;
                  dec_d   = Source[3];
                  rep_d   = Source[4];
               end else begin
                  bad_op_d = 1'b1;
               end
            end
         end

         S_XFER: begin
            if (xpt_q == XPT_END) begin
               // Repeat only while the decremented B is non-zero.
               if (rep_q && !b_zero_q) begin
                  state_d = S_TAIL;
                  xpt_d   = XPT_TAIL;
               end else begin
                  state_d = S_IDLE;
                  xpt_d   = 5'd0;
                  done_d  = 1'b1;
               end
            end else begin
               xpt_d = xpt_q + 5'd1;
               if (xpt_q == XPT_SAMPLE) begin
                  b_zero_d = b_zero;
               end
               if (xpt_q == XPT_PRE) begin
                  state_d = S_WAIT;
               end
            end
         end

         S_WAIT: begin
            // The limit check comes first so a stuck io_wait still leaves after
            // MAX_WAIT extra cycles; leaving with io_wait still high is a timeout.
            if (io_wait && (wait_cnt_q != WAIT_LIMIT)) begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end else begin
               state_d    = S_XFER;
               xpt_d      = XPT_END;
               wait_cnt_d = 8'd0;
               timeout_d  = io_wait;
            end
         end

         S_TAIL: begin
            if (xpt_q == XPT_LAST) begin
               state_d = S_IDLE;
               xpt_d   = 5'd0;
               done_d  = 1'b1;
            end else begin
               xpt_d = xpt_q + 5'd1;
            end
         end

         default: begin
            state_d = S_IDLE;
            xpt_d   = 5'd0;
         end
      endcase
   end

   // Outputs
   always_comb begin
      XPT        = xpt_q;
      notXPT     = ~xpt_q;
      busy       = (state_q != S_IDLE);
      dec        = dec_q;
      rep        = rep_q;
      pc_rewind  = (state_q == S_TAIL) && (xpt_q == XPT_LAST);
      done       = done_q;
      bad_op     = bad_op_q;
      io_timeout = timeout_q;
   end

   // XPT=10 is only ever held in S_WAIT.
   logic unused_wait_const;
   assign unused_wait_const = (XPT_WAIT == 5'd10);

endmodule
